// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, reads the active-low rows,
// debounces whole-frame scans and reports single key presses as a hex code plus a strobe.
module keypad_scanner #(
    parameter int unsigned CLOCKS_PER_COLUMN = 5000,
    parameter int unsigned DEBOUNCE_FRAMES   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  rowsN,
    output logic [3:0]  columnEnableN,
    output logic [3:0]  keyCode,
    output logic        keyStrobe,
    output logic        keyHeld,
    output logic [15:0] keyMap
);

    localparam int unsigned DivW = $clog2(CLOCKS_PER_COLUMN);
    localparam logic [DivW-1:0] DivLast = DivW'(CLOCKS_PER_COLUMN - 1);
    localparam logic [3:0] DebTarget = 4'(DEBOUNCE_FRAMES);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] CANDIDATE = 2'd1;
    localparam logic [1:0] HELD      = 2'd2;
    localparam logic [1:0] RELEASING = 2'd3;

    logic [3:0]      rows_meta, rows_sync;
    logic [DivW-1:0] div_q;
    logic [1:0]      col_q;
    logic [15:0]     acc_q, acc_d;
    logic            frame_end_q;
    logic            sample;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, cnt_inc;
    logic [15:0] cand_q, cand_d;
    logic [3:0]  code_d;
    logic        held_d, strobe_d;
    logic        map_none, map_single;

    function automatic logic [3:0] onehot_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Synchroniser idles at all-ones so a reset looks like "no key down".
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
        end else begin
            rows_meta <= rowsN;
            rows_sync <= rows_meta;
        end
    end

    assign sample        = (div_q == DivLast);
    assign columnEnableN = ~(4'b0001 << col_q);

    always_comb begin
        acc_d = acc_q;
        for (int r = 0; r < 4; r++) begin
            acc_d[4 * r + int'(col_q)] = ~rows_sync[r];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            col_q       <= 2'd0;
            acc_q       <= 16'h0000;
            keyMap      <= 16'h0000;
            frame_end_q <= 1'b0;
        end else begin
            frame_end_q <= sample && (col_q == 2'd3);
            if (sample) begin
                div_q <= '0;
                col_q <= col_q + 2'd1;
                acc_q <= acc_d;
                if (col_q == 2'd3) keyMap <= acc_d;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign map_none   = (keyMap == 16'h0000);
    assign map_single = !map_none && ((keyMap & (keyMap - 16'd1)) == 16'h0000);
    assign cnt_inc    = (cnt_q == DebTarget) ? cnt_q : cnt_q + 4'd1;

    // Evaluated only on the cycle keyMap holds a freshly completed frame.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        code_d   = keyCode;
        held_d   = keyHeld;
        strobe_d = 1'b0;
        if (frame_end_q) begin
            case (state_q)
                IDLE: begin
                    if (map_single) begin
                        cand_d = keyMap;
                        cnt_d  = 4'd1;
                        if (DebTarget == 4'd1) begin
                            code_d   = onehot_index(keyMap);
                            strobe_d = 1'b1;
                            held_d   = 1'b1;
                            state_d  = HELD;
                        end else begin
                            state_d = CANDIDATE;
                        end
                    end
                end
                CANDIDATE: begin
                    if (keyMap == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebTarget) begin
                            code_d   = onehot_index(cand_q);
                            strobe_d = 1'b1;
                            held_d   = 1'b1;
                            state_d  = HELD;
                        end
                    end else if (map_single) begin
                        cand_d = keyMap;
                        cnt_d  = 4'd1;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (map_none) begin
                        cnt_d = 4'd1;
                        if (DebTarget == 4'd1) begin
                            held_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = RELEASING;
                        end
                    end
                end
                default: begin
                    if (map_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebTarget) begin
                            held_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            cand_q    <= 16'h0000;
            keyCode   <= 4'd0;
            keyHeld   <= 1'b0;
            keyStrobe <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            keyCode   <= code_d;
            keyHeld   <= held_d;
            keyStrobe <= strobe_d;
        end
    end

endmodule
